// File: rtl/step_cursor_overlay.sv
// step_cursor_overlay
//
// Draws a vertical cursor bar on the diagram video stream at the motor's
// current step position. New step positions are accepted at any time but
// only take effect at the next frame start (in_vsync rising edge), so the
// bar never tears mid-frame. The whole stream is delayed by one clock.
//
// Optional feature: define CURSOR_BLINK_EN to blink the cursor with a
// 64-frame period (32 frames on, 32 off).
//
// Ports:
//   clock       pixel clock
//   reset_n     asynchronous active-low reset
//   step_index  step position to display, valid while step_valid is high
//   step_valid  one-cycle strobe
//   in_data     upstream RGB
//   in_de       upstream data enable
//   in_hsync    upstream hsync, active-high
//   in_vsync    upstream vsync, active-high
//   out_data    RGB with the cursor overlaid (0 during blanking)
//   out_de      in_de delayed one clock
//   out_hsync   in_hsync delayed one clock
//   out_vsync   in_vsync delayed one clock
//   cursor_x    committed cursor active-area x (debug view of the state)
module step_cursor_overlay #(
  parameter int          HACTIVE      = 1280,
  parameter int          VACTIVE      = 720,
  parameter int          X_ORIGIN     = 192,
  parameter int          STEP_PITCH   = 64,
  parameter int          CURSOR_WIDTH = 2,
  parameter int          Y_TOP        = 75,
  parameter int          Y_BOTTOM     = 500,
  parameter logic [23:0] CURSOR_COLOR = 24'hff0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  step_index,
  input  logic        step_valid,
  input  logic [23:0] in_data,
  input  logic        in_de,
  input  logic        in_hsync,
  input  logic        in_vsync,
  output logic [23:0] out_data,
  output logic        out_de,
  output logic        out_hsync,
  output logic        out_vsync,
  output logic [15:0] cursor_x
);

  localparam logic [15:0] HACT16  = 16'(HACTIVE);
  localparam logic [15:0] VACT16  = 16'(VACTIVE);
  localparam logic [15:0] XORG16  = 16'(X_ORIGIN);
  localparam logic [15:0] PITCH16 = 16'(STEP_PITCH);
  localparam logic [15:0] CW16    = 16'(CURSOR_WIDTH);
  localparam logic [15:0] YTOP16  = 16'(Y_TOP);
  localparam logic [15:0] YBOT16  = 16'(Y_BOTTOM);

  // Handshake: step_valid/step_index is a strobe with no ready; every
  // strobe is accepted in the cycle it is high. The video stream has no
  // backpressure either: one pixel in and one pixel out every clock.

  logic [15:0] x_cnt;
  logic [15:0] y_cnt;
  logic        pending;
  logic [7:0]  pending_index;
  logic [7:0]  committed_index;
  logic        armed;          // set by the first frame start after reset

  // out_de / out_vsync double as the registered copies used for edges.
  logic vsync_rise;
  logic de_fall;
  assign vsync_rise = in_vsync & ~out_vsync;
  assign de_fall    = out_de & ~in_de;

  // A strobe in the frame-start cycle wins over an older pending value.
  logic       commit_any;
  logic [7:0] commit_idx;
  always_comb begin
    commit_any = step_valid | pending;
    commit_idx = step_valid ? step_index : pending_index;
  end

  // Position counters, recovered from DE alone; they saturate, never wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_cnt <= 16'd0;
      y_cnt <= 16'd0;
    end else begin
      if (!in_de)                 x_cnt <= 16'd0;
      else if (x_cnt != 16'hffff) x_cnt <= x_cnt + 16'd1;

      if (vsync_rise)                       y_cnt <= 16'd0;
      else if (de_fall && y_cnt != 16'hffff) y_cnt <= y_cnt + 16'd1;
    end
  end

  // Step capture and frame-start commit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending         <= 1'b0;
      pending_index   <= 8'd0;
      committed_index <= 8'd0;
      armed           <= 1'b0;
    end else if (vsync_rise) begin
      armed   <= 1'b1;
      pending <= 1'b0;
      if (commit_any) committed_index <= commit_idx;
    end else if (step_valid) begin
      pending       <= 1'b1;
      pending_index <= step_index;
    end
  end

  // cursor_x trails committed_index by one clock; 255*64+192 fits 16 bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cursor_x <= XORG16;
    else          cursor_x <= XORG16 + 16'(committed_index) * PITCH16;
  end

  logic blink_on;
`ifdef CURSOR_BLINK_EN
  logic [5:0] frame_count;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= 6'd0;
    end else if (vsync_rise) begin
      // A moved cursor restarts the on-phase so it shows immediately.
      if (commit_any && commit_idx != committed_index) frame_count <= 6'd0;
      else                                             frame_count <= frame_count + 6'd1;
    end
  end
  assign blink_on = ~frame_count[5];
`else
  assign blink_on = 1'b1;
`endif

  // The extra y < VACTIVE term clips the bar to the active area.
  logic [16:0] cursor_end;
  logic        in_rows;
  logic        in_cols;
  logic        hit;
  always_comb begin
    cursor_end = {1'b0, cursor_x} + {1'b0, CW16};
    in_rows    = (y_cnt >= YTOP16) && (y_cnt <= YBOT16) && (y_cnt < VACT16);
    in_cols    = (x_cnt >= cursor_x) && ({1'b0, x_cnt} < cursor_end) &&
                 (cursor_x < HACT16);
    hit        = in_de && armed && blink_on && in_rows && in_cols;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= 24'd0;
      out_de    <= 1'b0;
      out_hsync <= 1'b0;
      out_vsync <= 1'b0;
    end else begin
      if (hit)        out_data <= CURSOR_COLOR;
      else if (in_de) out_data <= in_data;
      else            out_data <= 24'd0;
      out_de    <= in_de;
      out_hsync <= in_hsync;
      out_vsync <= in_vsync;
    end
  end

endmodule

// File: tb/tb_step_cursor_overlay.sv
// tb_step_cursor_overlay
//
// Drives synthetic frames (short lines except a few long lines of interest)
// into step_cursor_overlay. A frame-level model tracks which step is shown
// in each frame and where every driven pixel sits (line, pixel), and the
// expected output of each cycle is queued; a compare process checks the DUT
// one clock later. cursor_x and a few probed pixels are checked against
// hand-computed literals.
module tb_step_cursor_overlay;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  step_index;
  logic        step_valid;
  logic [23:0] in_data;
  logic        in_de;
  logic        in_hsync;
  logic        in_vsync;
  logic [23:0] out_data;
  logic        out_de;
  logic        out_hsync;
  logic        out_vsync;
  logic [15:0] cursor_x;

  step_cursor_overlay dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .step_index (step_index),
    .step_valid (step_valid),
    .in_data    (in_data),
    .in_de      (in_de),
    .in_hsync   (in_hsync),
    .in_vsync   (in_vsync),
    .out_data   (out_data),
    .out_de     (out_de),
    .out_hsync  (out_hsync),
    .out_vsync  (out_vsync),
    .cursor_x   (cursor_x)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [26:0] exp_q[$];   // {data, de, hsync, vsync}
  int          tag_q[$];   // line*4096+pixel for DE cycles, else -1

  // Frame-level model of the displayed step.
  bit m_armed   = 1'b0;
  bit m_pend    = 1'b0;
  bit m_vs_prev = 1'b0;
  int m_pidx    = 0;
  int m_cidx    = 0;
  int m_fc      = 0;

  logic [23:0] probe[4];
  int          probe_base = 192;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] pat(input int l, input int px);
    logic [31:0] lv;
    logic [31:0] pv;
    lv = l;
    pv = px;
    return {lv[7:0], pv[15:0]} ^ 24'h5a3c00;
  endfunction

  // Output pixel from the overlay rules, in active-area coordinates.
  function automatic logic [23:0] exp_pix(input logic de, input int line,
                                          input int px, input logic [23:0] d);
    int cx;
    bit on;
    cx = 192 + 64 * m_cidx;
    on = 1'b1;
`ifdef CURSOR_BLINK_EN
    on = (m_fc < 32);
`endif
    if (!de) return 24'h000000;
    if (m_armed && on && line >= 75 && line <= 500 &&
        px >= cx && px < cx + 2 && cx < 1280)
      return 24'hff0000;
    return d;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic [23:0] d, input logic de, input logic hs,
                       input logic vs, input logic sv, input logic [7:0] si,
                       input int line, input int px);
    int old;
    @(negedge clock);
    in_data    = d;
    in_de      = de;
    in_hsync   = hs;
    in_vsync   = vs;
    step_valid = sv;
    step_index = si;
    if (vs && !m_vs_prev) begin
      old     = m_cidx;
      m_armed = 1'b1;
      if (sv)          m_cidx = si;
      else if (m_pend) m_cidx = m_pidx;
      m_pend = 1'b0;
      if (m_cidx != old) m_fc = 0;
      else               m_fc = (m_fc + 1) % 64;
    end else if (sv) begin
      m_pend = 1'b1;
      m_pidx = si;
    end
    m_vs_prev = vs;
    exp_q.push_back({exp_pix(de, line, px, d), de, hs, vs});
    tag_q.push_back(de ? line * 4096 + px : -1);
  endtask

  // One frame: optional vsync (with optional strobe in the rise cycle),
  // then n_lines lines; long lines carry long_len pixels, others one.
  task automatic run_frame(input bit do_vs, input int n_lines, input int long_len,
                           input int vs_si, input int sa_line, input int sa_idx,
                           input int sb_line, input int sb_idx,
                           input int prev_cx, input int exp_cx);
    if (do_vs) begin
      drive(24'h0a0b0c, 1'b0, 1'b0, 1'b1, vs_si >= 0, 8'(vs_si), -1, 0);
      drive(24'h0a0b0c, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, -1, 0);
      chk("cursor_x_hold", {16'd0, cursor_x}, prev_cx);
      drive(24'h0a0b0c, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, -1, 0);
      chk("cursor_x_new", {16'd0, cursor_x}, exp_cx);
    end
    for (int l = 0; l < n_lines; l++) begin
      int len;
      bit lg;
      lg  = (n_lines < 200) ? (l == 100) :
            (l == 74 || l == 75 || l == 100 || l == 300 || l == 500 || l == 501);
      len = lg ? long_len : 1;
      for (int px = 0; px < len; px++)
        drive(pat(l, px), 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, l, px);
      drive(24'h123456, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, -1, 0);
      if (l == sa_line)
        drive(24'h654321, 1'b0, 1'b0, 1'b0, 1'b1, 8'(sa_idx), -1, 0);
      else if (l == sb_line)
        drive(24'h654321, 1'b0, 1'b0, 1'b0, 1'b1, 8'(sb_idx), -1, 0);
      else
        drive(24'h654321, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, -1, 0);
    end
  endtask

  // ---------------- compare process ----------------
  initial begin
    logic [26:0] e;
    int t;
    int p;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk("out_data", {8'd0, out_data}, {8'd0, e[26:3]});
        chk("out_syncs", {29'd0, out_de, out_hsync, out_vsync}, {29'd0, e[2:0]});
        if (t >= 0 && t / 4096 == 100) begin
          p = t % 4096;
          if (p >= probe_base - 1 && p <= probe_base + 2) probe[p - probe_base + 1] = out_data;
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    reset_n    = 1'b0;
    step_index = 8'd0;
    step_valid = 1'b0;
    in_data    = 24'h0;
    in_de      = 1'b0;
    in_hsync   = 1'b0;
    in_vsync   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_data", {8'd0, out_data}, 32'd0);
    chk("reset_syncs", {29'd0, out_de, out_hsync, out_vsync}, 32'd0);
    chk("reset_cursor_x", {16'd0, cursor_x}, 32'd192);
    @(negedge clock);
    reset_n = 1'b1;

    // Before any frame start the overlay is inert.
    run_frame(1'b0, 102, 200, -1, -1, 0, -1, 0, 192, 192);
    chk("inert_x192", {8'd0, probe[1]}, {8'd0, pat(100, 192)});

    // Index 0 committed at the first vsync; index 3 strobed at line 300.
    run_frame(1'b1, 502, 200, 0, 300, 3, -1, 0, 192, 192);
    chk("f0_x191", {8'd0, probe[0]}, {8'd0, pat(100, 191)});
    chk("f0_x192", {8'd0, probe[1]}, 32'h00ff0000);
    chk("f0_x193", {8'd0, probe[2]}, 32'h00ff0000);
    chk("f0_x194", {8'd0, probe[3]}, {8'd0, pat(100, 194)});

    // Index 3 shows at 384; strobes 5 then 7 in this frame.
    run_frame(1'b1, 502, 390, -1, 100, 5, 300, 7, 192, 384);
    // Last strobe wins: 640. Strobe 7 leaves a pending value.
    run_frame(1'b1, 502, 645, -1, 50, 7, -1, 0, 384, 640);
    // Strobe 2 in the vsync-rise cycle beats pending 7: 320.
    run_frame(1'b1, 502, 330, 2, -1, 0, -1, 0, 640, 320);
    // Nothing pending after the direct commit; strobe 19 for next frame.
    run_frame(1'b1, 502, 330, -1, 200, 19, -1, 0, 320, 320);
    // 1408 is beyond HACTIVE: stream passes unchanged.
    run_frame(1'b1, 502, 1412, -1, -1, 0, -1, 0, 320, 1408);

    // Reset in the middle of a line.
    drive(24'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, -1, 0);
    drive(24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, -1, 0);
    for (int px = 0; px < 10; px++) drive(pat(0, px), 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 0, px);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_data", {8'd0, out_data}, 32'd0);
    chk("midrst_syncs", {29'd0, out_de, out_hsync, out_vsync}, 32'd0);
    chk("midrst_cursor_x", {16'd0, cursor_x}, 32'd192);
    in_de      = 1'b0;
    in_data    = 24'h0;
    m_armed    = 1'b0;
    m_pend     = 1'b0;
    m_vs_prev  = 1'b0;
    m_cidx     = 0;
    m_fc       = 0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    run_frame(1'b0, 102, 200, -1, -1, 0, -1, 0, 192, 192);
    chk("post_rst_inert", {8'd0, probe[1]}, {8'd0, pat(100, 192)});
    run_frame(1'b1, 102, 200, -1, -1, 0, -1, 0, 192, 192);
    chk("post_rst_cursor", {8'd0, probe[1]}, 32'h00ff0000);

`ifdef CURSOR_BLINK_EN
    probe_base = 256;
    run_frame(1'b1, 102, 260, 1, -1, 0, -1, 0, 192, 256);
    chk("blink_f0", {8'd0, probe[1]}, 32'h00ff0000);
    for (int f = 1; f <= 64; f++) begin
      run_frame(1'b1, 102, 260, -1, -1, 0, -1, 0, 256, 256);
      if (f == 31) chk("blink_f31", {8'd0, probe[1]}, 32'h00ff0000);
      if (f == 32) chk("blink_f32", {8'd0, probe[1]}, {8'd0, pat(100, 256)});
      if (f == 63) chk("blink_f63", {8'd0, probe[1]}, {8'd0, pat(100, 256)});
      if (f == 64) chk("blink_f64", {8'd0, probe[1]}, 32'h00ff0000);
    end
`endif

    repeat (3) @(posedge clock);
    #2;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
